// File: rtl/mul_seq_param.sv
// Sequential radix-2^RADIX_BITS integer multiplier for RV32M/RV64M.
// Operands are converted to magnitudes at accept. A private 2*XLEN
// accumulator sums one partial product per BUSY cycle. The FIX cycle
// re-applies the sign and selects the low or high half of the product.
module mul_seq_param #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            start_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int N  = XLEN / RADIX_BITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude. The most negative value maps onto itself,
    // which read as unsigned is exactly 2^(XLEN-1).
    function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t              state_r;
    logic                mul_lo_r;
    logic                neg_r;
    logic [2*XLEN-1:0]   mcand_r;
    logic [XLEN-1:0]     mplier_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [CW-1:0]       cnt_r;
    logic [XLEN-1:0]     result_r;
    logic                ready_r;
    logic                valid_r;
    logic                busy_r;

    logic                a_neg_s;
    logic                b_neg_s;
    logic [2*XLEN-1:0]   pp_s;
    logic [XLEN-1:0]     mplier_shift_s;
    logic                last_iter_s;
    logic [2*XLEN-1:0]   product_s;
    logic                unused_f3_s;

    // funct3 bit 2 does not take part in op selection.
    assign unused_f3_s = funct3_i[2];

    // Operand sign flags: a is signed for MULH/MULHSU, b only for MULH.
    always_comb begin
        a_neg_s = 1'b0;
        b_neg_s = 1'b0;
        case (funct3_i[1:0])
            2'b01: begin
                a_neg_s = a_i[XLEN-1];
                b_neg_s = b_i[XLEN-1];
            end
            2'b10: begin
                a_neg_s = a_i[XLEN-1];
                b_neg_s = 1'b0;
            end
            default: begin
                a_neg_s = 1'b0;
                b_neg_s = 1'b0;
            end
        endcase
    end

    // Partial product of the shifted multiplicand and the low multiplier digit.
    always_comb begin
        pp_s = {(2*XLEN){1'b0}};
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (mplier_r[i]) begin
                pp_s = pp_s + (mcand_r << i);
            end else begin
                pp_s = pp_s;
            end
        end
    end

    // Iteration end: counter exhausted, or the remaining multiplier bits are zero.
    always_comb begin
        mplier_shift_s = mplier_r >> RADIX_BITS;
        if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
            last_iter_s = 1'b1;
        end else if ((EARLY_EXIT != 0) && (mplier_shift_s == {XLEN{1'b0}})) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
    end

    // Sign fix-up of the unsigned magnitude product, modulo 2^(2*XLEN).
    always_comb begin
        if (neg_r) begin
            product_s = ~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            product_s = acc_r;
        end
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_r  <= S_IDLE;
            mul_lo_r <= 1'b0;
            neg_r    <= 1'b0;
            mcand_r  <= {(2*XLEN){1'b0}};
            mplier_r <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {XLEN{1'b0}};
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        mul_lo_r <= (funct3_i[1:0] == 2'b00);
                        neg_r    <= a_neg_s ^ b_neg_s;
                        mcand_r  <= {{XLEN{1'b0}}, to_mag(a_i, a_neg_s)};
                        mplier_r <= to_mag(b_i, b_neg_s);
                        acc_r    <= {(2*XLEN){1'b0}};
                        cnt_r    <= CW'(N);
                        state_r  <= S_BUSY;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_r    <= acc_r + pp_s;
                    mcand_r  <= mcand_r << RADIX_BITS;
                    mplier_r <= mplier_shift_s;
                    cnt_r    <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    if (last_iter_s) begin
                        state_r <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_r <= mul_lo_r ? product_s[XLEN-1:0] : product_s[2*XLEN-1:XLEN];
                    state_r  <= S_DONE;
                    busy_r   <= 1'b0;
                    valid_r  <= 1'b1;
                end
                S_DONE: begin
                    if (result_ready_i) begin
                        state_r <= S_IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = ready_r;
    assign valid_o  = valid_r;
    assign busy_o   = busy_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_mul_seq_param.sv
// Directed bench for mul_seq_param. It runs two instances: one full-length
// (EARLY_EXIT=0) and one with early exit. Expected results go into a queue
// when an op is issued and are compared when valid_o appears.
module tb_mul_seq_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        start_full;
    logic        start_ee;
    logic [2:0]  funct3_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        result_ready_i;

    logic        ready_full, valid_full, busy_full;
    logic [31:0] result_full;
    logic        ready_ee, valid_ee, busy_ee;
    logic [31:0] result_ee;

    logic        sel_ee;
    logic        start_s;
    logic        ready_m, valid_m, busy_m;
    logic [31:0] result_m;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    int          lat;
    int          cnt;

    always #5 clk = ~clk;

    assign start_full = start_s & ~sel_ee;
    assign start_ee   = start_s & sel_ee;
    assign ready_m  = sel_ee ? ready_ee  : ready_full;
    assign valid_m  = sel_ee ? valid_ee  : valid_full;
    assign busy_m   = sel_ee ? busy_ee   : busy_full;
    assign result_m = sel_ee ? result_ee : result_full;

    mul_seq_param #(.XLEN(32), .RADIX_BITS(2), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_full),
        .ready_o(ready_full), .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i),
        .valid_o(valid_full), .result_ready_i(result_ready_i),
        .result_o(result_full), .busy_o(busy_full)
    );

    mul_seq_param #(.XLEN(32), .RADIX_BITS(2), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_ee),
        .ready_o(ready_ee), .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i),
        .valid_o(valid_ee), .result_ready_i(result_ready_i),
        .result_o(result_ee), .busy_o(busy_ee)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge in the cycle after accept; returns the cycle offset.
    task automatic wait_valid(output int l);
        l = 1;
        for (int k = 0; k < 100; k++) begin
            if (valid_m) return;
            next_cycle();
            l++;
        end
        check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 100; k++) begin
            if (ready_m) return;
            next_cycle();
        end
        check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic handshake(input string tag);
        result_ready_i = 1'b1;
        next_cycle();
        result_ready_i = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, valid_m}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, ready_m}, 64'd1);
    endtask

    task automatic run_op(input logic ee, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int exp_lat,
                          input int stall, input string tag);
        int l;
        sel_ee = ee;
        wait_ready();
        funct3_i = f3; a_i = a; b_i = b; start_s = 1'b1;
        exp_q.push_back(expv);
        next_cycle();
        start_s = 1'b0;
        a_i = $urandom; b_i = $urandom; funct3_i = 3'($urandom);
        wait_valid(l);
        check({tag, "_latency"}, 64'(l), 64'(exp_lat));
        got = exp_q.pop_front();
        check({tag, "_result"}, {32'd0, result_m}, {32'd0, got});
        for (int s = 0; s < stall; s++) begin
            next_cycle();
            check({tag, "_stall_valid"}, {63'd0, valid_m}, 64'd1);
            check({tag, "_stall_result"}, {32'd0, result_m}, {32'd0, got});
        end
        handshake(tag);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; start_s = 1'b0; funct3_i = 3'd0;
        a_i = 32'd0; b_i = 32'd0; result_ready_i = 1'b0; sel_ee = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {63'd0, ready_full}, 64'd1);
        check("rst_valid", {63'd0, valid_full}, 64'd0);
        check("rst_busy", {63'd0, busy_full}, 64'd0);
        check("rst_result", {32'd0, result_full}, 64'd0);
        rst = 1'b0;
        next_cycle();

        // Full-length signed/unsigned corners.
        run_op(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 18, 0, "mulhu_max");
        run_op(1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 18, 0, "mulh_minneg");
        run_op(1'b0, 3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 18, 0, "mul_minneg");
        run_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 18, 0, "mulhsu_m1");
        run_op(1'b0, 3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 18, 0, "mulh_m3x5");
        run_op(1'b0, 3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 18, 0, "mul_m3x5");

        // Early exit.
        run_op(1'b1, 3'b000, 32'd7, 32'd3, 32'd21, 3, 0, "ee_7x3");
        run_op(1'b1, 3'b000, 32'h12345678, 32'd0, 32'd0, 3, 0, "ee_b0");
        run_op(1'b1, 3'b000, 32'd1, 32'h80000000, 32'h80000000, 18, 0, "ee_msb");
        run_op(1'b1, 3'b100, 32'd7, 32'd3, 32'd21, 3, 0, "ee_f3bit2");

        // Backpressure: result held for 5 cycles.
        run_op(1'b0, 3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 18, 5, "stall");

        // start_i held high: re-accepted only in the IDLE cycle after the handshake.
        sel_ee = 1'b1;
        wait_ready();
        funct3_i = 3'b000; a_i = 32'd7; b_i = 32'd3; start_s = 1'b1;
        exp_q.push_back(32'd21);
        next_cycle();
        check("hold_not_ready", {63'd0, ready_m}, 64'd0);
        wait_valid(lat);
        check("hold_lat1", 64'(lat), 64'd3);
        got = exp_q.pop_front();
        check("hold_res1", {32'd0, result_m}, {32'd0, got});
        result_ready_i = 1'b1;
        next_cycle();
        result_ready_i = 1'b0;
        check("hold_idle_ready", {63'd0, ready_m}, 64'd1);
        check("hold_idle_busy", {63'd0, busy_m}, 64'd0);
        exp_q.push_back(32'd21);
        next_cycle();
        start_s = 1'b0;
        check("hold_reaccept_busy", {63'd0, busy_m}, 64'd1);
        check("hold_reaccept_ready", {63'd0, ready_m}, 64'd0);
        wait_valid(lat);
        check("hold_lat2", 64'(lat), 64'd3);
        got = exp_q.pop_front();
        check("hold_res2", {32'd0, result_m}, {32'd0, got});
        handshake("hold2");

        // Flush in BUSY cycle 4.
        sel_ee = 1'b0;
        wait_ready();
        funct3_i = 3'b000; a_i = 32'd5; b_i = 32'd9; start_s = 1'b1;
        next_cycle();
        start_s = 1'b0;
        repeat (3) next_cycle();
        check("flush_busy_before", {63'd0, busy_m}, 64'd1);
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        check("flush_ready", {63'd0, ready_m}, 64'd1);
        check("flush_busy", {63'd0, busy_m}, 64'd0);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (valid_m) cnt++;
            next_cycle();
        end
        check("flush_no_valid", 64'(cnt), 64'd0);

        // Flush together with start in IDLE: not accepted.
        flush_i = 1'b1; start_s = 1'b1;
        next_cycle();
        flush_i = 1'b0; start_s = 1'b0;
        check("flushstart_ready", {63'd0, ready_m}, 64'd1);
        check("flushstart_busy", {63'd0, busy_m}, 64'd0);
        next_cycle();
        check("flushstart_idle", {63'd0, busy_m}, 64'd0);

        // Reset in DONE.
        funct3_i = 3'b011; a_i = 32'hFFFFFFFF; b_i = 32'hFFFFFFFF; start_s = 1'b1;
        exp_q.push_back(32'hFFFFFFFE);
        next_cycle();
        start_s = 1'b0;
        wait_valid(lat);
        got = exp_q.pop_front();
        check("rstdone_result", {32'd0, result_m}, {32'd0, got});
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("rstdone_ready", {63'd0, ready_m}, 64'd1);
        check("rstdone_valid", {63'd0, valid_m}, 64'd0);
        check("rstdone_busy", {63'd0, busy_m}, 64'd0);
        check("rstdone_result0", {32'd0, result_m}, 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
